dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the core's load/store path. It accepts word-aligned requests with byte enables over a request/grant/response handshake and holds a word-organised data array. It performs byte-lane-masked writes and returns full-word read data after a configurable number of wait states. It sits between the load/store unit (initiator) and the data storage, and replaces the zero-latency tightly coupled path where memory latency must be modelled.

## Interface
- DATA_WIDTH, 32, data bus width in bits; only 32 is supported.
- ADDR_WIDTH, 32, byte address width.
- SIZE_WORDS, 1024, number of 32-bit words in the array; must be a power of two.
- WAIT_STATES, 1, extra cycles between grant and response; legal range 0..15.

- clk, in, 1, single clock; all logic is on the rising edge.
- rst, in, 1, synchronous, active-high reset.
- req_i, in, 1, initiator request valid.
- gnt_o, out, 1, request accepted this cycle. Combinational from req_i and state.
- addr_i, in, ADDR_WIDTH, byte address.
- we_i, in, 1, 1 = write, 0 = read.
- be_i, in, 4, byte enables; bit n selects byte lane n (bits 8n+7:8n).
- wdata_i, in, DATA_WIDTH, write data, lane-aligned.
- rvalid_o, out, 1, one-cycle response strobe.
- rdata_o, out, DATA_WIDTH, read data, full word, not shifted.
- err_o, out, 1, response error; valid only when rvalid_o = 1.

## Operation
- **States**
  - IDLE: no transaction in flight.
  - WAIT: counting wait states.
  - RESP: response cycle; the access is performed here.
- **Grant:** gnt_o = req_i AND (state == IDLE OR state == RESP). This allows back-to-back transactions.
- **Request capture:** on a cycle with gnt_o = 1, register addr_i, we_i, be_i, wdata_i and load wait counter = WAIT_STATES.
- **Transitions**
  - IDLE + grant → WAIT if WAIT_STATES > 0, else RESP.
  - IDLE without grant → IDLE.
  - WAIT: decrement counter each cycle. When counter == 1, go to RESP.
  - RESP + grant → WAIT or RESP (same rule as from IDLE).
  - RESP without grant → IDLE.
- **Addressing**
  - Word index = addr[log2(SIZE_WORDS)+1 : 2].
  - addr[1:0] is ignored; byte lanes are selected only by be.
  - The address is out of range when addr ≥ 4·SIZE_WORDS.
- **Access in RESP (in range)**
  - Write: update only the lanes with be set. rdata_o is unchanged; err_o = 0.
  - Read: rdata_o is loaded with the stored word, all four lanes regardless of be; err_o = 0.
- **Access in RESP (out of range)**
  - No array update.
  - rdata_o = 0, err_o = 1.
  - The same applies for both reads and writes.
- **be = 0000:** legal. A write changes nothing; a read returns the word. No error.
- **Read-after-write:** a read granted after a write to the same word returns the new data, because the write completes in the earlier RESP cycle.
- **Storage:** the array is not reset; contents survive rst.

## Timing
- **Latency:** request granted in cycle T → rvalid_o = 1 in cycle T+1+WAIT_STATES, for exactly one cycle.
- **Throughput:** one transaction per WAIT_STATES+1 cycles. With WAIT_STATES = 0, a request every cycle is granted every cycle.
- **Response outputs:** rvalid_o, rdata_o and err_o are registered.
  - rdata_o holds its last value between responses.
  - err_o is 0 whenever rvalid_o = 0.
- **Request hold:** while gnt_o = 0, the initiator must hold req_i and all request fields stable. Fields are sampled only in the grant cycle.
- **Reset values:** state = IDLE, counter = 0, rvalid_o = 0, rdata_o = 0, err_o = 0. gnt_o follows req_i in the first cycle after reset.
- **Reset during a transaction:** the transaction is dropped.
  - No array write.
  - No rvalid_o.
  - The state is IDLE in the cycle after rst is deasserted.
- **Reset with req_i high:** rst has priority; gnt_o = 0 while rst = 1.

## Test plan
- **Word write then read (WAIT_STATES=1):**
  - Write 0xDEADBEEF to 0x10 with be=1111, granted at T → rvalid at T+2, err=0.
  - Read 0x10 → rdata=0xDEADBEEF.
- **Partial write:**
  - Word at 0x20 holds 0x11223344. Write be=0010 with wdata=0x0000AA00 → read returns 0x1122AA44.
  - Write be=0000 → the word is unchanged.
- **Back-to-back (WAIT_STATES=0):**
  - req_i held high for 4 reads of 0x0, 0x4, 0x8, 0xC → gnt_o = 1 every cycle and four consecutive rvalid pulses with the matching data.
- **Out of range (SIZE_WORDS=1024):**
  - Write to 0x1000 → rvalid with err=1, rdata=0.
  - A following read of 0x0 shows that word is unmodified.
- **Stall:**
  - With WAIT_STATES=3, a second request raised the cycle after grant → gnt_o=0 for 3 cycles, then granted in the RESP cycle.
  - Responses arrive at T+4 and T+8.
- **Reset mid-transaction:**
  - With WAIT_STATES=3, assert rst for 1 cycle during WAIT of a write to 0x40 → no rvalid, and the word at 0x40 is unchanged on a later read.
  - The next request is granted immediately.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: request/grant/response handshake in front of a word array,
// with byte-lane-masked writes, full-word reads and a fixed number of wait states.
module dmem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int SIZE_WORDS  = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic [1:0]            state_o
);

    localparam int IDX_W = $clog2(SIZE_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:2]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [3:0]              be_q, be_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   mem_q [SIZE_WORDS];

    logic                    acc_go;
    logic [ADDR_WIDTH-1:2]   acc_addr;
    logic                    acc_we;
    logic [3:0]              acc_be;
    logic [DATA_WIDTH-1:0]   acc_wdata;
    logic                    acc_in_range;
    logic [IDX_W-1:0]        acc_idx;

    // Lane selection comes only from be_i, so the byte offset is deliberately dropped.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr_i[1:0];

    assign gnt_o = req_i && !rst && (state_q == S_IDLE || state_q == S_RESP);

    // The access fires on the edge that enters RESP; with zero wait states that is the
    // grant edge itself, so the live request fields are used instead of the captured ones.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        acc_go    = 1'b0;
        acc_addr  = addr_q;
        acc_we    = we_q;
        acc_be    = be_q;
        acc_wdata = wdata_q;
        case (state_q)
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    acc_go  = 1'b1;
                end
            end
            default: begin
                if (gnt_o) begin
                    addr_d  = addr_i[ADDR_WIDTH-1:2];
                    we_d    = we_i;
                    be_d    = be_i;
                    wdata_d = wdata_i;
                    cnt_d   = 4'(WAIT_STATES);
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d   = S_RESP;
                        acc_go    = 1'b1;
                        acc_addr  = addr_i[ADDR_WIDTH-1:2];
                        acc_we    = we_i;
                        acc_be    = be_i;
                        acc_wdata = wdata_i;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase

        acc_in_range = (acc_addr[ADDR_WIDTH-1:IDX_W+2] == '0);
        acc_idx      = acc_addr[IDX_W+1:2];

        rvalid_d = acc_go;
        err_d    = acc_go && !acc_in_range;
        rdata_d  = rdata_q;
        if (acc_go) begin
            if (!acc_in_range) begin
                rdata_d = '0;
            end else if (!acc_we) begin
                rdata_d = mem_q[acc_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= 4'd0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Storage is never reset; a reset edge simply suppresses the pending write.
    always_ff @(posedge clk) begin
        if (!rst && acc_go && acc_in_range && acc_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (0, 1 and 3 wait states) driven by directed
// and random requests, checked against a word-array reference model and latency rule.
module tb_dmem_responder;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req    [N];
  logic        gnt    [N];
  logic [31:0] addr   [N];
  logic        we     [N];
  logic [3:0]  be     [N];
  logic [31:0] wdata  [N];
  logic        rvalid [N];
  logic [31:0] rdata  [N];
  logic        err    [N];
  logic [1:0]  st     [N];

  always #5 clk = ~clk;

  int cyc = 0;
  bit rst_seen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  for (genvar g = 0; g < N; g++) begin : g_dut
    dmem_responder #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .SIZE_WORDS (1024),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .req_i   (req[g]),
      .gnt_o   (gnt[g]),
      .addr_i  (addr[g]),
      .we_i    (we[g]),
      .be_i    (be[g]),
      .wdata_i (wdata[g]),
      .rvalid_o(rvalid[g]),
      .rdata_o (rdata[g]),
      .err_o   (err[g]),
      .state_o (st[g])
    );
  end

  function automatic int ws(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  typedef struct {
    int          due;
    bit          w;
    logic [31:0] a;
    logic [3:0]  b;
    logic [31:0] d;
  } txn_t;

  txn_t        exp_q [N][$];
  logic [31:0] mem_m [N][1024];
  logic [31:0] last_rd [N];
  int          errors = 0;
  int          checks = 0;

  // Scoreboard: each response is computed from the model array at response time.
  txn_t        mt;
  logic [31:0] er;
  logic        ee;
  int          mi;
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (rst_seen) begin
        exp_q[k].delete();
        last_rd[k] = 32'h0;
        checks++;
        if (rvalid[k] !== 1'b0 || rdata[k] !== 32'h0 || err[k] !== 1'b0) begin
          errors++;
          $display("FAIL reset_outputs[%0d]: rvalid=%b rdata=%h err=%b, required 0/00000000/0",
                   k, rvalid[k], rdata[k], err[k]);
        end
      end else if (rvalid[k] === 1'b1) begin
        checks++;
        if (exp_q[k].size() == 0) begin
          errors++;
          $display("FAIL unexpected_rvalid[%0d]: rvalid=1 at cycle %0d, required no response", k, cyc);
        end else begin
          mt = exp_q[k].pop_front();
          if (mt.a >= 32'h1000) begin
            er = 32'h0;
            ee = 1'b1;
          end else begin
            mi = int'(mt.a >> 2);
            ee = 1'b0;
            if (mt.w) begin
              for (int b = 0; b < 4; b++)
                if (mt.b[b]) mem_m[k][mi][8*b +: 8] = mt.d[8*b +: 8];
              er = last_rd[k];
            end else begin
              er = mem_m[k][mi];
            end
          end
          last_rd[k] = er;
          if (cyc != mt.due) begin
            errors++;
            $display("FAIL latency[%0d]: response at cycle %0d, required cycle %0d", k, cyc, mt.due);
          end
          if (rdata[k] !== er || err[k] !== ee) begin
            errors++;
            $display("FAIL response[%0d]: addr=%h we=%b rdata=%h err=%b, required rdata=%h err=%b",
                     k, mt.a, mt.w, rdata[k], err[k], er, ee);
          end
        end
      end else begin
        checks++;
        if (rvalid[k] !== 1'b0 || err[k] !== 1'b0 || rdata[k] !== last_rd[k]) begin
          errors++;
          $display("FAIL idle_outputs[%0d]: rvalid=%b err=%b rdata=%h, required 0/0/%h",
                   k, rvalid[k], err[k], rdata[k], last_rd[k]);
        end
        if (exp_q[k].size() > 0 && exp_q[k][0].due < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_response[%0d]: none by cycle %0d, required at cycle %0d",
                   k, cyc, exp_q[k][0].due);
          void'(exp_q[k].pop_front());
        end
      end
    end
  end

  // Valid/ready rule: fields stay stable while req=1 and gnt=0; a grant consumes them.
  task automatic issue(input int k, input bit w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, output int tg);
    txn_t t;
    req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
    tg = -1;
    for (int n = 0; n < 40 && tg < 0; n++) begin
      @(negedge clk);
      if (gnt[k] === 1'b1) begin
        tg = cyc;
        t.due = cyc + 1 + ws(k); t.w = w; t.a = a; t.b = b; t.d = d;
        exp_q[k].push_back(t);
      end
      @(posedge clk); #1;
    end
    if (tg < 0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout[%0d]: no grant within 40 cycles, required a grant", k);
      req[k] = 1'b0;
    end
  endtask

  task automatic idle(input int k);
    req[k] = 1'b0; we[k] = 1'b0; be[k] = 4'h0;
    addr[k] = $urandom; wdata[k] = $urandom;
  endtask

  task automatic write_word(input int k, input logic [31:0] a, input logic [3:0] b,
                            input logic [31:0] d);
    int tg;
    issue(k, 1'b1, a, b, d, tg);
    idle(k);
    repeat (ws(k) + 1) @(posedge clk);
    #1;
  endtask

  task automatic read_word(input int k, input logic [31:0] a, output logic [31:0] d,
                           output logic v, output logic e);
    int tg;
    issue(k, 1'b0, a, 4'hF, 32'h0, tg);
    idle(k);
    repeat (ws(k) + 1) @(negedge clk);
    d = rdata[k]; v = rvalid[k]; e = err[k];
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: responses still outstanding after 60 cycles, required none");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      req[k] = 1'b1; we[k] = 1'b1; addr[k] = $urandom; be[k] = 4'hF; wdata[k] = $urandom;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (gnt[k] !== 1'b0) begin
        errors++;
        $display("FAIL gnt_in_reset[%0d]: gnt=%b, required 0", k, gnt[k]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (gnt[k] !== 1'b1) begin
        errors++;
        $display("FAIL gnt_after_reset[%0d]: gnt=%b, required 1", k, gnt[k]);
      end
      idle(k);
    end
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (gnt[k] !== 1'b0) begin
        errors++;
        $display("FAIL gnt_no_req[%0d]: gnt=%b, required 0", k, gnt[k]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_word_rw();
    int tg;
    logic [31:0] d;
    logic v, e;
    issue(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, tg);
    idle(1);
    @(negedge clk);
    checks++;
    if (rvalid[1] !== 1'b0) begin
      errors++;
      $display("FAIL write_early_rvalid: rvalid=%b at T+1, required 0", rvalid[1]);
    end
    @(negedge clk);
    checks++;
    if (rvalid[1] !== 1'b1 || err[1] !== 1'b0 || cyc != tg + 2) begin
      errors++;
      $display("FAIL write_resp: rvalid=%b err=%b cycle=%0d, required 1/0 at %0d",
               rvalid[1], err[1], cyc, tg + 2);
    end
    @(posedge clk); #1;
    read_word(1, 32'h10, d, v, e);
    checks++;
    if (v !== 1'b1 || e !== 1'b0 || d !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL word_read: rvalid=%b err=%b rdata=%h, required 1/0/deadbeef", v, e, d);
    end
  endtask

  task automatic test_partial();
    logic [31:0] d;
    logic v, e;
    write_word(1, 32'h20, 4'hF, 32'h11223344);
    write_word(1, 32'h21, 4'b0010, 32'h0000AA00);
    read_word(1, 32'h20, d, v, e);
    checks++;
    if (v !== 1'b1 || e !== 1'b0 || d !== 32'h1122AA44) begin
      errors++;
      $display("FAIL partial_write: rvalid=%b err=%b rdata=%h, required 1/0/1122aa44", v, e, d);
    end
    write_word(1, 32'h20, 4'b0000, 32'hFFFFFFFF);
    read_word(1, 32'h23, d, v, e);
    checks++;
    if (v !== 1'b1 || e !== 1'b0 || d !== 32'h1122AA44) begin
      errors++;
      $display("FAIL be_zero_write: rvalid=%b err=%b rdata=%h, required 1/0/1122aa44", v, e, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    logic [31:0] raw;
    int tg [4];
    int tw, tr;
    for (int i = 0; i < 4; i++) begin
      vals[i] = $urandom;
      write_word(0, 32'(4 * i), 4'hF, vals[i]);
    end
    for (int i = 0; i < 4; i++) issue(0, 1'b0, 32'(4 * i), 4'h0, 32'h0, tg[i]);
    idle(0);
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (tg[i] != tg[0] + i) begin
        errors++;
        $display("FAIL b2b_grant[%0d]: granted at %0d, required %0d", i, tg[i], tg[0] + i);
      end
    end
    @(negedge clk);
    checks++;
    if (rvalid[0] !== 1'b1 || rdata[0] !== vals[3]) begin
      errors++;
      $display("FAIL b2b_last_read: rvalid=%b rdata=%h, required 1/%h", rvalid[0], rdata[0], vals[3]);
    end
    @(posedge clk); #1;
    raw = $urandom;
    issue(0, 1'b1, 32'h14, 4'hF, raw, tw);
    issue(0, 1'b0, 32'h14, 4'hF, 32'h0, tr);
    idle(0);
    @(negedge clk);
    checks++;
    if (tr != tw + 1 || rvalid[0] !== 1'b1 || rdata[0] !== raw) begin
      errors++;
      $display("FAIL read_after_write: grants %0d/%0d rvalid=%b rdata=%h, required consecutive 1/%h",
               tw, tr, rvalid[0], rdata[0], raw);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    logic [31:0] v0, d;
    logic v, e;
    int tg;
    v0 = $urandom;
    write_word(1, 32'h0, 4'hF, v0);
    issue(1, 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, tg);
    idle(1);
    repeat (2) @(negedge clk);
    checks++;
    if (rvalid[1] !== 1'b1 || err[1] !== 1'b1 || rdata[1] !== 32'h0) begin
      errors++;
      $display("FAIL oor_write: rvalid=%b err=%b rdata=%h, required 1/1/00000000",
               rvalid[1], err[1], rdata[1]);
    end
    @(posedge clk); #1;
    read_word(1, 32'h0, d, v, e);
    checks++;
    if (v !== 1'b1 || e !== 1'b0 || d !== v0) begin
      errors++;
      $display("FAIL oor_no_alias: rvalid=%b err=%b rdata=%h, required 1/0/%h", v, e, d, v0);
    end
    read_word(1, 32'hFFFFFFFC, d, v, e);
    checks++;
    if (v !== 1'b1 || e !== 1'b1 || d !== 32'h0) begin
      errors++;
      $display("FAIL oor_read: rvalid=%b err=%b rdata=%h, required 1/1/00000000", v, e, d);
    end
  endtask

  task automatic test_stall();
    logic [31:0] a;
    int ta, tb;
    a = $urandom;
    issue(2, 1'b1, 32'h30, 4'hF, a, ta);
    issue(2, 1'b0, 32'h30, 4'hF, 32'h0, tb);
    idle(2);
    checks++;
    if (tb != ta + 4) begin
      errors++;
      $display("FAIL stall_grant: second grant at %0d, required %0d", tb, ta + 4);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rvalid[2] !== 1'b1 || rdata[2] !== a || cyc != ta + 8) begin
      errors++;
      $display("FAIL stall_second_resp: rvalid=%b rdata=%h cycle=%0d, required 1/%h at %0d",
               rvalid[2], rdata[2], cyc, a, ta + 8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] v_old, d;
    logic v, e;
    int tg, c0;
    bit seen;
    v_old = $urandom;
    write_word(2, 32'h40, 4'hF, v_old);
    issue(2, 1'b1, 32'h40, 4'hF, ~v_old, tg);
    idle(2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rvalid[2] !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_drop_rvalid: rvalid seen after reset, required none");
    end
    @(posedge clk); #1;
    c0 = cyc;
    issue(2, 1'b0, 32'h40, 4'hF, 32'h0, tg);
    idle(2);
    checks++;
    if (tg != c0) begin
      errors++;
      $display("FAIL reset_next_grant: granted at %0d, required %0d", tg, c0);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rvalid[2] !== 1'b1 || rdata[2] !== v_old) begin
      errors++;
      $display("FAIL reset_no_write: rvalid=%b rdata=%h, required 1/%h", rvalid[2], rdata[2], v_old);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] a;
    int tg;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 16; i++) write_word(k, 32'(4 * i), 4'hF, $urandom);
      for (int n = 0; n < 60; n++) begin
        if ($urandom_range(0, 7) == 0) a = $urandom | 32'h1000;
        else a = 32'(4 * $urandom_range(0, 15)) | 32'($urandom_range(0, 3));
        issue(k, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, tg);
        if ($urandom_range(0, 1) == 1) begin
          idle(k);
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
      end
      idle(k);
      drain();
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      idle(k);
      last_rd[k] = 32'h0;
    end
    test_reset();
    test_word_rw();
    test_partial();
    test_back_to_back();
    test_out_of_range();
    test_stall();
    test_reset_mid();
    test_random();
    drain();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
